tx_msg_builder: RTL and testbench
=================================

Name: tx_msg_builder

Overview:
- Downstream neighbour of the protocol-layer transmit FSM in the TCPC.
- When the FSM raises PassBytes, this block checks that the bus is idle, then reads the SOP type and the TX buffer contents.
- It streams header, data and CRC-32 bytes to the PHY encoder over a valid/ready interface.
- It reports the outcome back to the FSM with a MessageSentToPhy or MessageDiscardedBusIdle pulse.

Parameters:
- ADDR_W, 5: TX buffer address width.
- BUF_DEPTH, 30: maximum bytes per message (2 header bytes + up to 28 data bytes).
- BIST_BYTES, 64: byte count for BIST carrier mode (optional feature only).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- PassBytes  in  1  level from the transmit FSM; requests one message build.
- TRANSMIT  in  8  TCPC TRANSMIT register; [2:0] is the SOP type.
- TX_BUF_BYTE_COUNT  in  8  bytes in the TX buffer (header + data).
- bus_idle  in  1  CC line idle indication from the PHY.
- buf_rd_addr  out  ADDR_W  TX buffer read address; synchronous read, 1-cycle latency.
- buf_rd_data  in  8  TX buffer read data.
- phy_tx_data  out  8  byte to the PHY.
- phy_tx_sop  out  3  SOP type, held stable for the whole frame.
- phy_tx_last  out  1  marks the final byte.
- phy_tx_valid  out  1  byte valid.
- phy_tx_ready  in  1  PHY accepts the byte.
- MessageSentToPhy  out  1  1-cycle pulse after the last byte is accepted.
- MessageDiscardedBusIdle  out  1  1-cycle pulse when the bus is busy at start.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, armed=1, CRC register 0xFFFFFFFF.
- One-hot states: IDLE, CHECK_BUS, FETCH, SEND_DATA, SEND_CRC, DONE, DISCARD.
- IDLE:
  - If PassBytes && armed: latch TRANSMIT[2:0] into phy_tx_sop, latch len = clamp(TX_BUF_BYTE_COUNT, 2, BUF_DEPTH), clear armed, go to CHECK_BUS.
  - Any other SOP value is accepted; gating is the FSM's job.
- CHECK_BUS:
  - bus_idle=0 goes to DISCARD.
  - bus_idle=1 sets idx=0, drives buf_rd_addr=0, goes to FETCH.
- FETCH: the byte arrives the following cycle; register it into phy_tx_data, set phy_tx_valid=1, go to SEND_DATA.
- SEND_DATA:
  - Hold data and valid until phy_tx_ready.
  - On accept: update CRC with the byte, drop valid, idx++.
  - If idx==len go to SEND_CRC; otherwise drive buf_rd_addr=idx and go to FETCH.
- Throughput is at most 1 byte per 2 cycles. This is acceptable against the BMC line rate.
- CRC: USB PD CRC-32, polynomial 0x04C11DB7, init 0xFFFFFFFF, LSB-first (reflected) bit processing.
- SEND_CRC:
  - Sends the inverted CRC as 4 bytes, least significant byte first, each held until accepted.
  - phy_tx_last=1 on the 4th CRC byte only.
- DONE: pulse MessageSentToPhy for 1 cycle, reinitialise CRC, go to IDLE.
- DISCARD: pulse MessageDiscardedBusIdle for 1 cycle, go to IDLE. No byte is ever presented to the PHY.
- Re-arm: armed is set again once PassBytes is sampled low in IDLE. A level held across a frame therefore never starts a second frame.
- PassBytes dropping mid-frame: the frame still completes. The FSM owns aborts via reset.
- Bus going busy mid-frame: ignored. Collision handling belongs to the PHY.
- Reset asserted mid-frame:
  - Immediate return to the reset state; phy_tx_valid drops asynchronously.
  - The PHY sees a truncated frame with no phy_tx_last, and must drop it.
- Counter width: idx is ADDR_W+1 bits, so len==BUF_DEPTH does not wrap.

Optional Feature:
- Macro TX_BIST_CARRIER_EN.
- Defined: SOP type 3'b111 skips the buffer reads and CRC.
  - Sends BIST_BYTES bytes of 0xAA, with last on the final byte, then pulses MessageSentToPhy.
  - The bus idle check still applies.
- Undefined: 3'b111 is treated like any other SOP type (normal buffer message).

Decomposition:
- Package tcpc_pkg holds:
  - state encodings;
  - SOP type constants (SOP=0, SOP'=1, SOP''=2, HARD_RESET=5, CABLE_RESET=6, BIST=7);
  - CRC constants: polynomial 0x04C11DB7, init 0xFFFFFFFF, residual 0xC704DD7B.
- Sub-module crc32_pd_byte: purely combinational next-CRC from (crc_in[31:0], byte[7:0]); reused by the RX checker.

Test Plan:
- Bus idle, count=2, header bytes 0x41,0x00, ready always 1:
  - exactly 6 valid handshakes, phy_tx_last on the 6th only;
  - bench CRC over all 6 bytes reaches residual 0xC704DD7B;
  - MessageSentToPhy pulses once.
- bus_idle=0 at start: MessageDiscardedBusIdle pulses once, zero phy_tx_valid cycles, back in IDLE next cycle.
- Count=30 with random ready stalls up to 5 cycles:
  - 34 bytes emitted in order at buf_rd_addr 0..29;
  - data stable while valid && !ready.
- Count=0, then count=200: clamped to 2 and 30 data bytes respectively.
- PassBytes held high 100 cycles after MessageSentToPhy: no second frame; low 1 cycle then high starts a new frame.
- reset low while the 10th byte is pending: phy_tx_valid=0 immediately, all outputs 0, next frame's CRC is correct.

Source files
------------

// File: rtl/tcpc_pkg.sv
// Shared TCPC definitions: transmit builder state encodings, SOP type codes
// and the USB PD CRC-32 constants used by both the TX builder and RX checker.
package tcpc_pkg;

    // One-hot state encoding for the transmit message builder.
    typedef enum logic [6:0] {
        ST_IDLE      = 7'b000_0001,
        ST_CHECK_BUS = 7'b000_0010,
        ST_FETCH     = 7'b000_0100,
        ST_SEND_DATA = 7'b000_1000,
        ST_SEND_CRC  = 7'b001_0000,
        ST_DONE      = 7'b010_0000,
        ST_DISCARD   = 7'b100_0000
    } tx_state_e;

    // SOP type codes as carried in TRANSMIT[2:0].
    localparam logic [2:0] SOP_TYPE_SOP         = 3'd0;
    localparam logic [2:0] SOP_TYPE_SOP_P       = 3'd1;
    localparam logic [2:0] SOP_TYPE_SOP_PP      = 3'd2;
    localparam logic [2:0] SOP_TYPE_HARD_RESET  = 3'd5;
    localparam logic [2:0] SOP_TYPE_CABLE_RESET = 3'd6;
    localparam logic [2:0] SOP_TYPE_BIST        = 3'd7;

    // CRC-32 constants in conventional (MSB-first) notation.
    localparam logic [31:0] CRC_POLY     = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUAL = 32'hC704_DD7B;

    // Bit-reverse a 32-bit word; the LSB-first CRC register runs on the mirrored polynomial.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

endpackage

// File: rtl/crc32_pd_byte.sv
// USB PD CRC-32 single-byte update, bits consumed LSB first.
// Register is held in reflected form, so the transmitted CRC is simply its
// complement sent least significant byte first.
module crc32_pd_byte
    import tcpc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);

    // Eight reflected shift/XOR steps unrolled into one combinational stage.
    always_comb begin
        // NOTE: every variable written in always_comb gets a value first, so no path can leave it holding state (a latch).
        crc_out = crc_in ^ {24'h00_0000, byte_in};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY_REFL) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/tx_msg_builder.sv
// Transmit message builder: on PassBytes, checks the CC bus, streams header,
// data and CRC-32 bytes to the PHY and reports sent/discarded to the FSM.
// Optional build macro TX_BIST_CARRIER_EN: SOP type 3'b111 sends BIST_BYTES
// bytes of 0xAA with no buffer reads and no CRC.
module tx_msg_builder
    import tcpc_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int BUF_DEPTH  = 30,
    parameter int BIST_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PassBytes,
    input  logic [7:0]        TRANSMIT,
    input  logic [7:0]        TX_BUF_BYTE_COUNT,
    input  logic              bus_idle,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [7:0]        buf_rd_data,
    output logic [7:0]        phy_tx_data,
    output logic [2:0]        phy_tx_sop,
    output logic              phy_tx_last,
    output logic              phy_tx_valid,
    input  logic              phy_tx_ready,
    output logic              MessageSentToPhy,
    output logic              MessageDiscardedBusIdle
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(BUF_DEPTH);
    localparam logic [ADDR_W:0] MIN_LEN = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

    tx_state_e       state_q, state_d;
    logic            armed_q;
    logic [ADDR_W:0] len_q, idx_q, idx_inc, len_clamped;
    logic [31:0]     crc_q, crc_next;
    logic [1:0]      crc_cnt_q;
    logic            accept, last_data;
    logic            is_bist, bist_final, bist_penult;
    logic            unused_transmit_hi;

    assign accept             = phy_tx_valid & phy_tx_ready;
    assign idx_inc            = idx_q + IDX_ONE;
    assign last_data          = (idx_inc == len_q);
    assign unused_transmit_hi = ^TRANSMIT[7:3];

    crc32_pd_byte u_crc (
        .crc_in  (crc_q),
        .byte_in (phy_tx_data),
        .crc_out (crc_next)
    );

    // Clamp the requested byte count to a header-only minimum and the buffer depth.
    always_comb begin
        if (TX_BUF_BYTE_COUNT < 8'd2) begin
            len_clamped = MIN_LEN;
        end else if (TX_BUF_BYTE_COUNT > 8'(BUF_DEPTH)) begin
            len_clamped = MAX_LEN;
        end else begin
            len_clamped = TX_BUF_BYTE_COUNT[ADDR_W:0];
        end
    end

`ifdef TX_BIST_CARRIER_EN
    localparam int BIST_W = $clog2(BIST_BYTES + 1);

    logic              bist_q;
    logic [BIST_W-1:0] bist_cnt_q;

    assign is_bist     = bist_q;
    assign bist_final  = (bist_cnt_q == BIST_W'(BIST_BYTES - 1));
    assign bist_penult = (bist_cnt_q == BIST_W'(BIST_BYTES - 2));

    // Remember carrier mode at frame start and count carrier bytes accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bist_q     <= 1'b0;
            bist_cnt_q <= '0;
        end else if (state_q == ST_IDLE && PassBytes && armed_q) begin
            bist_q     <= (TRANSMIT[2:0] == SOP_TYPE_BIST);
            bist_cnt_q <= '0;
        end else if (state_q == ST_SEND_DATA && accept && bist_q) begin
            bist_cnt_q <= bist_cnt_q + BIST_W'(1);
        end
    end
`else
    localparam int unused_bist_bytes = BIST_BYTES;

    assign is_bist     = 1'b0;
    assign bist_final  = 1'b0;
    assign bist_penult = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the buffer read address and the outcome pulses.
    always_comb begin
        state_d                 = state_q;
        buf_rd_addr             = '0;
        MessageSentToPhy        = 1'b0;
        MessageDiscardedBusIdle = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PassBytes && armed_q) state_d = ST_CHECK_BUS;
            end
            ST_CHECK_BUS: begin
                if (!bus_idle)    state_d = ST_DISCARD;
                else if (is_bist) state_d = ST_SEND_DATA;
                else              state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                if (accept) begin
                    if (is_bist) begin
                        if (bist_final) state_d = ST_DONE;
                    end else if (last_data) begin
                        state_d = ST_SEND_CRC;
                    end else begin
                        buf_rd_addr = idx_inc[ADDR_W-1:0];
                        state_d     = ST_FETCH;
                    end
                end
            end
            ST_SEND_CRC: begin
                if (accept && crc_cnt_q == 2'd3) state_d = ST_DONE;
            end
            ST_DONE: begin
                MessageSentToPhy = 1'b1;
                state_d          = ST_IDLE;
            end
            ST_DISCARD: begin
                MessageDiscardedBusIdle = 1'b1;
                state_d                 = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: arming, frame parameters, byte/CRC staging and the PHY handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q      <= 1'b1;
            len_q        <= '0;
            idx_q        <= '0;
            crc_q        <= CRC_INIT;
            crc_cnt_q    <= '0;
            phy_tx_data  <= '0;
            phy_tx_sop   <= '0;
            phy_tx_last  <= 1'b0;
            phy_tx_valid <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!PassBytes) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q    <= 1'b0;
                        phy_tx_sop <= TRANSMIT[2:0];
                        len_q      <= len_clamped;
                    end
                end
                ST_CHECK_BUS: begin
                    if (bus_idle) begin
                        idx_q <= '0;
                        if (is_bist) begin
                            phy_tx_data  <= 8'hAA;
                            phy_tx_valid <= 1'b1;
                            phy_tx_last  <= (BIST_BYTES == 1);
                        end
                    end
                end
                ST_FETCH: begin
                    phy_tx_data  <= buf_rd_data;
                    phy_tx_valid <= 1'b1;
                end
                ST_SEND_DATA: begin
                    if (accept) begin
                        if (is_bist) begin
                            if (bist_final) begin
                                phy_tx_valid <= 1'b0;
                                phy_tx_last  <= 1'b0;
                            end else begin
                                phy_tx_last <= bist_penult;
                            end
                        end else begin
                            idx_q <= idx_inc;
                            crc_q <= crc_next;
                            if (last_data) begin
                                // First CRC byte goes out straight away; valid stays high.
                                phy_tx_data <= ~crc_next[7:0];
                                crc_cnt_q   <= '0;
                            end else begin
                                phy_tx_valid <= 1'b0;
                            end
                        end
                    end
                end
                ST_SEND_CRC: begin
                    if (accept) begin
                        if (crc_cnt_q == 2'd3) begin
                            phy_tx_valid <= 1'b0;
                            phy_tx_last  <= 1'b0;
                        end else begin
                            phy_tx_data <= ~crc_q[15:8];
                            crc_q       <= {8'h00, crc_q[31:8]};
                            crc_cnt_q   <= crc_cnt_q + 2'd1;
                            phy_tx_last <= (crc_cnt_q == 2'd2);
                        end
                    end
                end
                ST_DONE: begin
                    crc_q <= CRC_INIT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_msg_builder.sv
// Bench for tx_msg_builder: buffer RAM model, randomly stalling PHY sink and
// a scoreboard of expected bytes built from an MSB-first serial CRC model.
`timescale 1ns/1ps
module tb_tx_msg_builder;

    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } sb_t;

    typedef struct {
        logic [2:0] sop;
        logic [7:0] count;
        bit         idle;
        bit         stall;
        bit         fixed_hdr;
        bit         drop;
        int         exp_len;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              PassBytes = 1'b0;
    logic [7:0]        TRANSMIT = '0;
    logic [7:0]        TX_BUF_BYTE_COUNT = '0;
    logic              bus_idle = 1'b1;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [7:0]        buf_rd_data = '0;
    logic [7:0]        phy_tx_data;
    logic [2:0]        phy_tx_sop;
    logic              phy_tx_last;
    logic              phy_tx_valid;
    logic              phy_tx_ready = 1'b0;
    logic              MessageSentToPhy;
    logic              MessageDiscardedBusIdle;

    always #5 clk = ~clk;

    tx_msg_builder #(.ADDR_W(ADDR_W), .BUF_DEPTH(30), .BIST_BYTES(64)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .PassBytes               (PassBytes),
        .TRANSMIT                (TRANSMIT),
        .TX_BUF_BYTE_COUNT       (TX_BUF_BYTE_COUNT),
        .bus_idle                (bus_idle),
        .buf_rd_addr             (buf_rd_addr),
        .buf_rd_data             (buf_rd_data),
        .phy_tx_data             (phy_tx_data),
        .phy_tx_sop              (phy_tx_sop),
        .phy_tx_last             (phy_tx_last),
        .phy_tx_valid            (phy_tx_valid),
        .phy_tx_ready            (phy_tx_ready),
        .MessageSentToPhy        (MessageSentToPhy),
        .MessageDiscardedBusIdle (MessageDiscardedBusIdle)
    );

    // TX buffer with one-cycle synchronous read.
    logic [7:0] mem [0:31];
    always @(posedge clk) buf_rd_data <= mem[buf_rd_addr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Serial CRC-32, each byte fed LSB first into an MSB-first register.
    function automatic logic [31:0] crc_u_byte(input logic [31:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ b[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C1_1DB7;
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // PHY sink / monitor state (owned by the monitor process).
    int          acc_cnt = 0, valid_cyc = 0, sent_cnt = 0, disc_cnt = 0;
    int          stall_left = 0;
    bit          stall_mode = 1'b0;
    int          stall_after = 32'h4000_0000;
    bit          prev_pend = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;
    logic [31:0] crc_acc = 32'hFFFF_FFFF;
    logic [31:0] last_residual = '0;
    sb_t         sb[$];

    // Sample on the falling edge, choose ready for the coming rising edge, score accepted bytes.
    always @(negedge clk) begin : mon
        bit  rdy;
        sb_t e;
        if (!reset) begin
            prev_pend    = 1'b0;
            crc_acc      = 32'hFFFF_FFFF;
            phy_tx_ready = 1'b0;
        end else begin
            if (phy_tx_valid)            valid_cyc++;
            if (MessageSentToPhy)        sent_cnt++;
            if (MessageDiscardedBusIdle) disc_cnt++;
            if (prev_pend) begin
                check("hold_valid", phy_tx_valid, 1);
                check("hold_data", phy_tx_data, prev_data);
                check("hold_last", phy_tx_last, prev_last);
            end
            rdy = 1'b1;
            if (stall_mode && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            if (acc_cnt >= stall_after) rdy = 1'b0;
            phy_tx_ready = rdy;
            if (phy_tx_valid && rdy) begin
                acc_cnt++;
                check("byte_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("tx_data", phy_tx_data, e.data);
                    check("tx_last", phy_tx_last, e.last);
                end
                crc_acc = crc_u_byte(crc_acc, phy_tx_data);
                if (phy_tx_last) begin
                    last_residual = crc_acc;
                    crc_acc       = 32'hFFFF_FFFF;
                end else begin
                    last_residual = '0;
                end
                if (stall_mode) stall_left = $urandom_range(0, 5);
            end
            prev_pend = phy_tx_valid && !rdy;
            prev_data = phy_tx_data;
            prev_last = phy_tx_last;
        end
    end

    // Load the buffer, queue the expected frame, then raise PassBytes after one low cycle.
    task automatic start_frame(input vec_t v, output int acc0, output int s0, output int d0, output int vc0);
        logic [31:0] cu, tx;
        logic [7:0]  base;
        base = 8'($urandom);
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37) + base;
        if (v.fixed_hdr) begin
            mem[0] = 8'h41;
            mem[1] = 8'h00;
        end
        if (v.idle) begin
            cu = 32'hFFFF_FFFF;
            for (int i = 0; i < v.exp_len; i++) begin
                sb.push_back('{data: mem[i], last: 1'b0});
                cu = crc_u_byte(cu, mem[i]);
            end
            tx = ~bitrev32(cu);
            for (int k = 0; k < 4; k++) sb.push_back('{data: tx[8*k +: 8], last: (k == 3)});
        end
        @(negedge clk);
        stall_mode        = v.stall;
        TRANSMIT          = {5'($urandom), v.sop};
        TX_BUF_BYTE_COUNT = v.count;
        bus_idle          = v.idle;
        PassBytes         = 1'b0;
        acc0 = acc_cnt;
        s0   = sent_cnt;
        d0   = disc_cnt;
        vc0  = valid_cyc;
        @(negedge clk);
        PassBytes = 1'b1;
    endtask

    task automatic wait_frame(input bit drop_early, input int s0, input int d0);
        int budget;
        budget = 3000;
        while (sent_cnt == s0 && disc_cnt == d0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (drop_early && budget == 2990) PassBytes = 1'b0;
        end
        check("frame_done_in_time", budget > 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame(input vec_t v, input int acc0, input int s0, input int d0, input int vc0, input string tag);
        int hs;
        hs = v.idle ? v.exp_len + 4 : 0;
        check($sformatf("%s_handshakes", tag), acc_cnt - acc0, hs);
        check($sformatf("%s_sent_pulses", tag), sent_cnt - s0, v.idle ? 1 : 0);
        check($sformatf("%s_discard_pulses", tag), disc_cnt - d0, v.idle ? 0 : 1);
        check($sformatf("%s_scoreboard_empty", tag), sb.size(), 0);
        check($sformatf("%s_sop", tag), phy_tx_sop, v.sop);
        if (v.idle) check($sformatf("%s_crc_residual", tag), last_residual, 32'hC704_DD7B);
        else        check($sformatf("%s_valid_cycles", tag), valid_cyc - vc0, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v;
        int   acc0, s0, d0, vc0, budget;

        //            sop    count   idle stall hdr drop len
        vecs[0] = '{3'd0, 8'd2,   1, 0, 1, 0, 2};
        vecs[1] = '{3'd1, 8'd2,   0, 0, 0, 0, 2};
        vecs[2] = '{3'd2, 8'd30,  1, 1, 0, 0, 30};
        vecs[3] = '{3'd5, 8'd0,   1, 0, 0, 0, 2};
        vecs[4] = '{3'd6, 8'd200, 1, 1, 0, 0, 30};
        vecs[5] = '{3'd7, 8'd5,   1, 1, 0, 1, 5};

        repeat (3) @(negedge clk);
        check("rst_valid", phy_tx_valid, 0);
        check("rst_data", phy_tx_data, 0);
        check("rst_sop", phy_tx_sop, 0);
        check("rst_last", phy_tx_last, 0);
        check("rst_addr", buf_rd_addr, 0);
        check("rst_sent", MessageSentToPhy, 0);
        check("rst_discard", MessageDiscardedBusIdle, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            start_frame(vecs[i], acc0, s0, d0, vc0);
            wait_frame(vecs[i].drop, s0, d0);
            check_frame(vecs[i], acc0, s0, d0, vc0, $sformatf("vec%0d", i));
        end

        // PassBytes held high long after the frame: exactly one frame.
        v = '{3'd2, 8'd3, 1, 0, 0, 0, 3};
        start_frame(v, acc0, s0, d0, vc0);
        wait_frame(1'b0, s0, d0);
        repeat (100) @(negedge clk);
        check_frame(v, acc0, s0, d0, vc0, "held_level");

        // One low cycle re-arms and the next high level starts a new frame.
        v = '{3'd1, 8'd4, 1, 0, 0, 0, 4};
        start_frame(v, acc0, s0, d0, vc0);
        wait_frame(1'b0, s0, d0);
        check_frame(v, acc0, s0, d0, vc0, "rearm");

        // Reset while the 10th byte is waiting for ready.
        v = '{3'd2, 8'd20, 1, 0, 0, 0, 20};
        stall_after = acc_cnt + 9;
        start_frame(v, acc0, s0, d0, vc0);
        budget = 2000;
        while (!((acc_cnt - acc0) == 9 && phy_tx_valid) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("midreset_reached_byte10", budget > 0, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_valid", phy_tx_valid, 0);
        check("midreset_data", phy_tx_data, 0);
        check("midreset_sop", phy_tx_sop, 0);
        check("midreset_last", phy_tx_last, 0);
        check("midreset_addr", buf_rd_addr, 0);
        check("midreset_sent", MessageSentToPhy, 0);
        check("midreset_discard", MessageDiscardedBusIdle, 0);
        sb.delete();
        stall_after = 32'h4000_0000;
        PassBytes   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        v = '{3'd1, 8'd6, 1, 1, 0, 0, 6};
        start_frame(v, acc0, s0, d0, vc0);
        wait_frame(1'b0, s0, d0);
        check_frame(v, acc0, s0, d0, vc0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
